// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator feeding the instruction-fetch stage.
//
// Holds the architectural fetch PC and offers it to fetch over a
// valid/ready handshake, advancing by STEP on every accepted fetch.
// Traps beat branch/jump redirects, which beat the sequential increment.
// A halt request parks the block in HALT until reset.
//
// Optional build macro: PC_ALIGN_CHECK_EN
//   defined   - redirect targets with addr[1:0] != 0 are rejected and
//               reported on misalign / misalign_addr (traps never checked)
//   undefined - targets load verbatim, misalign outputs tied to 0
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   trap_valid/_target   trap redirect (highest priority)
//   redir_valid/_target  branch/jump redirect from execute
//   halt_req             stop fetching (honoured in RUN only)
//   out_valid/_ready/_pc fetch request handshake
//   halted               block is parked in HALT
//   fetch_count          number of accepted fetches (wraps)
//   misalign/_addr       rejected misaligned redirect report
module pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned STEP     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trap_valid,
  input  logic [63:0] trap_target,
  input  logic        redir_valid,
  input  logic [63:0] redir_target,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic        halted,
  output logic [63:0] fetch_count,
  output logic        misalign,
  output logic [63:0] misalign_addr
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]  state;
  logic [63:0] pc_q;
  logic [63:0] cnt_q;
  logic [63:0] next_pc;
  logic        active;
  logic        fire;
  logic        redir_bad;
  logic        redir_ok;

  // BOOT and RUN both accept redirects; only RUN offers a fetch.
  assign active    = (state == S_BOOT) || (state == S_RUN);
  assign out_valid = (state == S_RUN);
  assign halted    = (state == S_HALT);
  assign out_pc    = pc_q;
  assign fetch_count = cnt_q;
  assign fire      = out_valid & out_ready;

`ifdef PC_ALIGN_CHECK_EN
  assign redir_bad = redir_valid & (redir_target[1:0] != 2'b00);
`else
  assign redir_bad = 1'b0;
`endif
  assign redir_ok  = redir_valid & ~redir_bad;

  always_comb begin
    next_pc = pc_q;
    if (trap_valid)    next_pc = trap_target;
    else if (redir_ok) next_pc = redir_target;
    else if (fire)     next_pc = pc_q + 64'(STEP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BOOT;
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          pc_q  <= next_pc;
          state <= S_RUN;
        end
        S_RUN: begin
          pc_q <= next_pc;
          if (fire)     cnt_q <= cnt_q + 64'd1;
          if (halt_req) state <= S_HALT;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_BOOT;
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Flag pulses for one cycle after a rejected redirect; the address
  // is sticky until the next rejection or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= active & redir_bad;
      if (active & redir_bad) misalign_addr <= redir_target;
    end
  end
`else
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif

endmodule
